quad_beam_scaler: RTL and testbench

// - Four-channel, 12-bit, double-banked trigger scaler for the beam-trigger scaler chain.
// - Counts per-channel hit windows into the active bank while the frozen bank is read out.
// - Readout uses a 96-bit cascade shift path, so N blocks form a shift register toward the scaler RAM writer.
// - Single-clock design: the window CE divider is internal, and no clock-crossing flag sync is needed.

---
 rtl/scaler_pkg.sv | 18 +
 rtl/ce_divider.sv | 27 ++
 rtl/quad_beam_scaler.sv | 70 +++++++
 tb/tb_quad_beam_scaler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared widths, bank type and saturating increment for the quad beam scaler.
// Pure declarations: no latency, no flow control.
package scaler_pkg;

  localparam int NCHAN  = 4;
  localparam int CWIDTH = 12;
  localparam int BANK_W = NCHAN * CWIDTH;

  typedef logic [NCHAN-1:0][CWIDTH-1:0] bank_t;

  // Adds one when inc is set, holding at all-ones instead of wrapping.
  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v, input logic inc);
    if (inc && (v != {CWIDTH{1'b1}}))
      return v + 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Window divider: ce pulses for one clock every CLK_DIVIDE clocks, first pulse CLK_DIVIDE-1 clocks after reset.
// Free-running, no backpressure.
module ce_divider #(
  parameter int CLK_DIVIDE = 6
) (
  input  logic clk,
  input  logic rst,
  output logic ce
);

  localparam int CW = (CLK_DIVIDE > 2) ? $clog2(CLK_DIVIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIVIDE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign ce = (cnt == LAST);

endmodule

// File: rtl/quad_beam_scaler.sv
// Double-banked 4x12-bit hit-window scaler; counts land on count_o one clock after the window ce.
// No backpressure: the inactive bank is cascaded/loaded via shift_i while the active bank keeps counting.
module quad_beam_scaler
  import scaler_pkg::*;
#(
  parameter int CLK_DIVIDE = 6
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NCHAN-1:0]    count_i,
  input  logic                bank_i,
  input  logic [1:0]          shift_i,
  input  logic [2*BANK_W-1:0] pc_i,
  output logic [2*BANK_W-1:0] pc_o,
  output logic [2*BANK_W-1:0] count_o
);

  logic             ce;
  logic             act;
  logic             sw;
  logic [NCHAN-1:0] flag;
  logic [NCHAN-1:0] hit;
  bank_t            bank     [2];
  bank_t            bank_nxt [2];

  ce_divider #(.CLK_DIVIDE(CLK_DIVIDE)) u_div (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .ce  (ce)
  );

  // A hit in the closing cycle of the window still counts for that window.
  assign hit = flag | count_i;
  assign sw  = (bank_i != act);

  // Per bank: clear-on-switch > cascade load (inactive only) > increment (active only).
  // On a switch the window result goes to the new bank, so nothing is lost.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      bank_nxt[k] = bank[k];
      if (sw && (bank_i == 1'(k))) begin
        for (int n = 0; n < NCHAN; n++)
          bank_nxt[k][n] = {{(CWIDTH-1){1'b0}}, ce & hit[n]};
      end else if (shift_i[k] && (act != 1'(k))) begin
        bank_nxt[k] = pc_i[BANK_W*k +: BANK_W];
      end else if (ce && !sw && (act == 1'(k))) begin
        for (int n = 0; n < NCHAN; n++)
          bank_nxt[k][n] = sat_inc(bank[k][n], hit[n]);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      act     <= 1'b0;
      flag    <= '0;
      bank[0] <= '0;
      bank[1] <= '0;
    end else begin
      act     <= bank_i;
      flag    <= ce ? '0 : hit;
      bank[0] <= bank_nxt[0];
      bank[1] <= bank_nxt[1];
    end
  end

  assign pc_o    = {bank[1], bank[0]};
  assign count_o = pc_o;

endmodule

// File: tb/tb_quad_beam_scaler.sv
// Self-checking bench for quad_beam_scaler: vector table, directed corner sequences, random vs. reference model.
module tb_quad_beam_scaler;

  localparam int CLK_DIVIDE = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ci  = '0;
  logic        bi  = 1'b0;
  logic [1:0]  si  = '0;
  logic [95:0] pci = '0;
  logic [95:0] pc_o;
  logic [95:0] count_o;

  int n_pass  = 0;
  int n_total = 0;

  quad_beam_scaler #(.CLK_DIVIDE(CLK_DIVIDE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .count_i  (ci),
    .bank_i   (bi),
    .shift_i  (si),
    .pc_i     (pci),
    .pc_o     (pc_o),
    .count_o  (count_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer counters per bank/channel, window position, hit memory.
  int m_bank [2][4];
  bit m_flag [4];
  int m_win;
  bit m_act;

  function automatic logic [95:0] m_pack();
    logic [95:0] v;
    v = '0;
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 4; n++)
        v[48*k + 12*n +: 12] = 12'(m_bank[k][n]);
    return v;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] c, input logic b,
                            input logic [1:0] s, input logic [95:0] p);
    bit ce;
    int hv [4];
    int nb [2][4];
    int ia;
    int ib;
    if (r) begin
      for (int k = 0; k < 2; k++)
        for (int n = 0; n < 4; n++)
          m_bank[k][n] = 0;
      for (int n = 0; n < 4; n++) m_flag[n] = 1'b0;
      m_win = 0;
      m_act = 1'b0;
    end else begin
      ce = (m_win == CLK_DIVIDE - 1);
      for (int n = 0; n < 4; n++) hv[n] = (m_flag[n] || c[n]) ? 1 : 0;
      nb = m_bank;
      ia = m_act ? 1 : 0;
      ib = m_act ? 0 : 1;
      if (b != m_act) begin
        for (int n = 0; n < 4; n++) nb[ib][n] = ce ? hv[n] : 0;
      end else begin
        if (ce)
          for (int n = 0; n < 4; n++)
            nb[ia][n] = (m_bank[ia][n] + hv[n] > 4095) ? 4095 : m_bank[ia][n] + hv[n];
        if (s[ib])
          for (int n = 0; n < 4; n++) nb[ib][n] = int'(p[48*ib + 12*n +: 12]);
      end
      m_bank = nb;
      for (int n = 0; n < 4; n++) m_flag[n] = ce ? 1'b0 : (m_flag[n] | c[n]);
      m_win = ce ? 0 : m_win + 1;
      m_act = b;
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] c, input logic b,
                     input logic [1:0] s, input logic [95:0] p);
    rst = r; ci = c; bi = b; si = s; pci = p;
    model_step(r, c, b, s, p);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", name, got, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  c;
    logic        b;
    logic [1:0]  s;
    logic [95:0] p;
    logic [95:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b1, 4'h0, 1'b0, 2'b00, 96'h0, 96'h0};
    tbl[1]  = '{1'b1, 4'h0, 1'b0, 2'b00, 96'h0, 96'h0};
    tbl[2]  = '{1'b0, 4'h1, 1'b0, 2'b00, 96'h0, 96'h0};
    tbl[3]  = '{1'b0, 4'h1, 1'b0, 2'b00, 96'h0, 96'h0};
    tbl[4]  = '{1'b0, 4'h1, 1'b0, 2'b00, 96'h0, 96'h0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 2'b00, 96'h0, 96'h0};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 2'b00, 96'h0, 96'h0};
    tbl[7]  = '{1'b0, 4'h4, 1'b0, 2'b00, 96'h0, {48'h0, 48'h000001000001}};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 2'b00, 96'h0, {48'h0, 48'h000001000001}};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 2'b01, {48'h0, 48'h123456789ABC}, {48'h0, 48'h123456789ABC}};
    tbl[10] = '{1'b0, 4'h8, 1'b1, 2'b10, {48'hFFFFFFFFFFFF, 48'h0}, {48'h0, 48'h123456789ABC}};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 2'b00, 96'h0, {48'h0, 48'h123456789ABC}};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 2'b00, 96'h0, {48'h0, 48'h123456789ABC}};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 2'b00, 96'h0, {48'h001000000000, 48'h123456789ABC}};
    tbl[14] = '{1'b1, 4'h0, 1'b1, 2'b00, 96'h0, 96'h0};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].c, tbl[i].b, tbl[i].s, tbl[i].p);
      chk($sformatf("tbl%0d_count", i), count_o, tbl[i].exp);
      chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].exp);
    end

    // Reset held two cycles, then 18 clocks of ch0 = three windows.
    cyc(1'b1, 4'h0, 1'b0, 2'b00, 96'h0);
    cyc(1'b1, 4'h0, 1'b0, 2'b00, 96'h0);
    chk("reset_count", count_o, 96'h0);
    chk("reset_pc", pc_o, 96'h0);
    for (int i = 0; i < 18; i++) cyc(1'b0, 4'h1, 1'b0, 2'b00, 96'h0);
    chk("single_ch0", count_o, 96'd3);

    // Three pulses on ch2 inside one window count once.
    for (int i = 0; i < 5; i++) cyc(1'b0, (i % 2 == 0) ? 4'h4 : 4'h0, 1'b0, 2'b00, 96'h0);
    chk("dedupe_pre_ce", count_o, 96'd3);
    cyc(1'b0, 4'h0, 1'b0, 2'b00, 96'h0);
    chk("dedupe_ch2", count_o, {48'h0, 48'h000001000003});

    // Switch to B: B cleared, A frozen, B counts.
    cyc(1'b0, 4'h0, 1'b1, 2'b00, 96'h0);
    chk("switch_clear", count_o, {48'h0, 48'h000001000003});
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'h1, 1'b1, 2'b00, 96'h0);
    chk("switch_b_counts", count_o, {48'h000000000001, 48'h000001000003});

    // Cascade load of inactive A, then ignored load of active B.
    cyc(1'b0, 4'h0, 1'b1, 2'b01, {48'h0, 48'h123456789ABC});
    chk("shift_a", count_o, {48'h000000000001, 48'h123456789ABC});
    cyc(1'b0, 4'h1, 1'b1, 2'b10, {48'hAAAAAAAAAAAA, 48'h0});
    chk("shift_active_b", pc_o, {48'h000000000001, 48'h123456789ABC});
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h1, 1'b1, 2'b00, 96'h0);
    chk("b_still_counts", count_o, {48'h000000000002, 48'h123456789ABC});

    // Mid-window reset drops flags and restarts the divider.
    cyc(1'b0, 4'hF, 1'b1, 2'b00, 96'h0);
    cyc(1'b0, 4'hF, 1'b1, 2'b00, 96'h0);
    cyc(1'b1, 4'h0, 1'b1, 2'b00, 96'h0);
    chk("midop_reset", count_o, 96'h0);
    cyc(1'b0, 4'h2, 1'b0, 2'b00, 96'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b0, 2'b00, 96'h0);
    chk("midop_no_early_ce", count_o, 96'h0);
    cyc(1'b0, 4'h0, 1'b0, 2'b00, 96'h0);
    chk("midop_restart", count_o, 96'h000000001000);

    // Saturation of ch3 at 4095.
    cyc(1'b1, 4'h0, 1'b0, 2'b00, 96'h0);
    for (int i = 0; i < 4100 * CLK_DIVIDE; i++) cyc(1'b0, 4'h8, 1'b0, 2'b00, 96'h0);
    chk("sat_ch3", count_o, {48'h0, 48'hFFF000000000});
    for (int i = 0; i < 2 * CLK_DIVIDE; i++) cyc(1'b0, 4'h8, 1'b0, 2'b00, 96'h0);
    chk("sat_hold", count_o, {48'h0, 48'hFFF000000000});

    // Randomized traffic against the model.
    begin
      logic        rb;
      logic [1:0]  rs;
      logic [95:0] rp;
      logic        rr;
      rb = 1'b0;
      cyc(1'b1, 4'h0, 1'b0, 2'b00, 96'h0);
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(39) == 0) rb = ~rb;
        rs = ($urandom_range(5) == 0) ? 2'($urandom) : 2'b00;
        rp = {$urandom, $urandom, $urandom};
        rr = ($urandom_range(499) == 0);
        cyc(rr, 4'($urandom), rb, rs, rp);
        chk($sformatf("rand%0d_count", i), count_o, m_pack());
        chk($sformatf("rand%0d_pc", i), pc_o, m_pack());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
